dsp_out_formatter: RTL and testbench
====================================

Name: dsp_out_formatter

Overview:
- Output stage directly downstream of the FIR filter.
- Consumes the full-precision FIR result (2*DATA_WIDTH+5 bits, valid/ready) and rescales it by a programmable right shift with round-half-up.
- Saturates the result to DATA_WIDTH and buffers it in a first-word-fall-through FIFO that drives the chip-level dst stream.
- Reports saturation events to software through a sticky flag and a counter.

Parameters:
- IN_WIDTH, 37, width of the signed FIR output word (2*DATA_WIDTH+5).
- DATA_WIDTH, 16, width of the signed output word.
- DEPTH, 8, FIFO depth in words; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- shift  in  6  right-shift amount, sampled per accepted sample.
- clear_sat  in  1  clears sat_flag and sat_count.
- src_data_in  in  IN_WIDTH  signed FIR result.
- src_valid_in  in  1  src_data_in is valid.
- src_ready_out  out  1  block can accept a sample this cycle.
- dst_data_out  out  DATA_WIDTH  signed formatted sample at the FIFO head.
- dst_valid_out  out  1  FIFO is not empty.
- dst_ready_in  in  1  downstream consumes the head word.
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- sat_flag  out  1  sticky: at least one sample saturated.
- sat_count  out  16  number of saturated samples; holds at 0xFFFF.

Behaviour:
- Reset (rst high at an edge): wr_ptr, rd_ptr, level, s1_valid, sat_flag and sat_count all go to 0. Consequently dst_valid_out=0 and dst_data_out=0. src_ready_out=1 in the first cycle after reset.
- FIFO storage is not reset.
- Reset asserted mid-operation discards all buffered and in-flight samples.
- Accept: a sample is accepted when src_valid_in && src_ready_out.
- src_ready_out = (DEPTH - level) > s1_valid. This is combinational and does not credit a same-cycle read.
- Format, combinational on the accepted sample:
  - Effective shift s = min(shift, IN_WIDTH-1).
  - Add rounding term: 1<<(s-1) if s>0, else 0. The addition is sign-extended to IN_WIDTH+1 bits so it cannot overflow.
  - Arithmetic right shift by s.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], i.e. [-32768, 32767] at defaults.
  - sat_hit = 1 when clamping occurred.
- Stage register S1: on accept, it loads the formatted word and sat_hit and sets s1_valid=1. With no accept, s1_valid is cleared.
- FIFO write: when s1_valid=1, S1 is written at wr_ptr on the next edge; room is guaranteed by the ready rule.
- FIFO read: when dst_valid_out && dst_ready_in, rd_ptr advances. dst_data_out is mem[rd_ptr] while level != 0, and 0 otherwise.
- Pointers wrap modulo DEPTH.
- level update: +1 on write only, -1 on read only, unchanged on simultaneous read and write. It never exceeds DEPTH or goes below 0.
- Latency: a sample accepted at edge k is written at edge k+1, so dst_valid_out is high after edge k+1. That is 2 cycles from accept to output.
- Full-rate throughput of 1 word/cycle is sustained while dst_ready_in=1.
- dst_data_out is held stable while dst_valid_out=1 and dst_ready_in=0.
- Saturation accounting, performed on the edge when S1 writes with sat_hit=1:
  - sat_flag is set.
  - sat_count increments, saturating at 0xFFFF.
- clear_sat=1 zeroes both sat_flag and sat_count. If a sat_hit write occurs in the same cycle, the result is sat_flag=1 and sat_count=1 (set wins).
- shift changes take effect on the next accepted sample; words already in S1 or the FIFO are unaffected.

Test Plan:
- Rounding, shift=15, dst_ready_in=1:
  - Input 16384 -> output 1.
  - Input -16384 -> output 0.
  - Input 49152 -> output 2.
  - Each output appears 2 cycles after accept.
- Saturation, shift=15:
  - Input 2^31 -> 32767.
  - Input -2^31 -> -32768.
  - Afterwards sat_flag=1 and sat_count=2.
  - Pulsing clear_sat then gives sat_flag=0 and sat_count=0.
- Full and backpressure, dst_ready_in=0, src_valid_in=1 with inputs 1..10 at shift=0:
  - Exactly 8 samples are accepted; src_ready_out then goes low and level=8.
  - After dst_ready_in=1, the outputs are 1..8 in order, followed by 9 and 10.
- Simultaneous read and write at level=4 with streaming on both sides -> level stays 4 for 20 cycles with no data loss or reordering.
- Shift clamp: shift=63, input -1 -> output 0 (s=36 with rounding); input -2^36 -> output -1.
- Reset mid-stream: assert rst for 1 cycle at level=5 with s1_valid=1 -> next cycle level=0, dst_valid_out=0, sat_count=0, and the discarded data never appears.

Source files
------------

// File: rtl/dsp_out_formatter.sv
// FIR output formatter: round-half-up right shift, saturation to DATA_WIDTH,
// one-word staging register and a first-word-fall-through FIFO toward dst.
// Saturation events are reported through a sticky flag and a saturating counter.
module dsp_out_formatter #(
  parameter int IN_WIDTH   = 37,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [5:0]                  shift,
  input  logic                        clear_sat,
  input  logic [IN_WIDTH-1:0]         src_data_in,
  input  logic                        src_valid_in,
  output logic                        src_ready_out,
  output logic [DATA_WIDTH-1:0]       dst_data_out,
  output logic                        dst_valid_out,
  input  logic                        dst_ready_in,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        sat_flag,
  output logic [15:0]                 sat_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PAD = IN_WIDTH - DATA_WIDTH + 2;
  localparam logic [5:0] MAX_SHIFT = 6'(IN_WIDTH - 1);
  localparam logic signed [IN_WIDTH:0] MAX_V = {{PAD{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] MIN_V = {{PAD{1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_sat_q, s1_sat_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  sat_flag_q, sat_flag_d;
  logic [15:0]           sat_count_q, sat_count_d;

  logic                  accept;
  logic                  rd_en;
  logic [5:0]            eff_shift;
  logic signed [IN_WIDTH:0] ext, rnd, sum, shd;
  logic [DATA_WIDTH-1:0] fmt_data;
  logic                  fmt_sat;

  // Handshake: one slot of headroom is reserved for the word sitting in S1.
  always_comb begin
    src_ready_out = (LW'(DEPTH) - level_q) > {{(LW-1){1'b0}}, s1_valid_q};
    accept        = src_valid_in && src_ready_out;
    dst_valid_out = (level_q != '0);
    rd_en         = dst_valid_out && dst_ready_in;
    dst_data_out  = dst_valid_out ? mem_q[rd_ptr_q] : '0;
    level         = level_q;
    sat_flag      = sat_flag_q;
    sat_count     = sat_count_q;
  end

  // Rescale with round-half-up; the extra top bit keeps the rounding add from overflowing.
  always_comb begin
    eff_shift = (shift > MAX_SHIFT) ? MAX_SHIFT : shift;
    ext       = {src_data_in[IN_WIDTH-1], src_data_in};
    rnd       = '0;
    if (eff_shift != 6'd0) rnd = {{IN_WIDTH{1'b0}}, 1'b1} << (eff_shift - 6'd1);
    sum       = ext + rnd;
    shd       = sum >>> eff_shift;
    fmt_sat   = 1'b0;
    fmt_data  = shd[DATA_WIDTH-1:0];
    if (shd > MAX_V) begin
      fmt_data = MAX_V[DATA_WIDTH-1:0];
      fmt_sat  = 1'b1;
    end else if (shd < MIN_V) begin
      fmt_data = MIN_V[DATA_WIDTH-1:0];
      fmt_sat  = 1'b1;
    end
  end

  // Next-state for S1, FIFO pointers/occupancy and saturation accounting.
  always_comb begin
    s1_valid_d  = accept;
    s1_data_d   = accept ? fmt_data : s1_data_q;
    s1_sat_d    = accept ? fmt_sat : s1_sat_q;
    wr_ptr_d    = s1_valid_q ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d     = level_q;
    if (s1_valid_q && !rd_en) level_d = level_q + LW'(1);
    else if (!s1_valid_q && rd_en) level_d = level_q - LW'(1);
    sat_flag_d  = sat_flag_q;
    sat_count_d = sat_count_q;
    if (clear_sat) begin
      sat_flag_d  = 1'b0;
      sat_count_d = '0;
    end
    if (s1_valid_q && s1_sat_q) begin
      sat_flag_d = 1'b1;
      if (sat_count_d != 16'hFFFF) sat_count_d = sat_count_d + 16'd1;
    end
  end

  // Control state with synchronous reset; a reset drops anything buffered or in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      sat_flag_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      sat_flag_q  <= sat_flag_d;
      sat_count_q <= sat_count_d;
    end
  end

  // Datapath storage is not reset; validity is tracked by s1_valid_q and level_q.
  always_ff @(posedge clk) begin
    s1_data_q <= s1_data_d;
    s1_sat_q  <= s1_sat_d;
    if (s1_valid_q) mem_q[wr_ptr_q] <= s1_data_q;
  end

endmodule

// File: tb/tb_dsp_out_formatter.sv
// Directed bench for dsp_out_formatter: table of format vectors plus
// hand-written sequences for saturation clear, backpressure, streaming and reset.
module tb_dsp_out_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  shift;
  logic        clear_sat;
  logic [36:0] src_data_in;
  logic        src_valid_in;
  logic        src_ready_out;
  logic [15:0] dst_data_out;
  logic        dst_valid_out;
  logic        dst_ready_in;
  logic [3:0]  level;
  logic        sat_flag;
  logic [15:0] sat_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [5:0]  sh;
    logic [36:0] din;
    logic [15:0] q;
    bit          sat;
  } vec_t;

  vec_t vq[$];

  dsp_out_formatter dut (
    .clk(clk), .rst(rst), .shift(shift), .clear_sat(clear_sat),
    .src_data_in(src_data_in), .src_valid_in(src_valid_in), .src_ready_out(src_ready_out),
    .dst_data_out(dst_data_out), .dst_valid_out(dst_valid_out), .dst_ready_in(dst_ready_in),
    .level(level), .sat_flag(sat_flag), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int sh, input longint d, input int q, input bit s);
    vec_t v;
    v.sh  = sh[5:0];
    v.din = d[36:0];
    v.q   = q[15:0];
    v.sat = s;
    vq.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    shift        = v.sh;
    src_data_in  = v.din;
    src_valid_in = 1'b1;
    dst_ready_in = 1'b1;
    chk("vec_ready", src_ready_out, 1);
    tick();
    src_valid_in = 1'b0;
    chk("vec_not_yet_valid", dst_valid_out, 0);
    tick();
    chk("vec_valid", dst_valid_out, 1);
    chk("vec_data", $signed(dst_data_out), $signed(v.q));
    if (v.sat) exp_cnt++;
    chk("vec_sat_count", sat_count, exp_cnt);
    tick();
    chk("vec_drained", dst_valid_out, 0);
  endtask

  initial begin
    int nin, nout, acc, lvl_checks;
    bit acc_now;
    vec_t v77;

    rst = 1'b1; shift = '0; clear_sat = 1'b0; src_data_in = '0;
    src_valid_in = 1'b0; dst_ready_in = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_dst_valid", dst_valid_out, 0);
    chk("rst_dst_data", dst_data_out, 0);
    chk("rst_level", level, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_src_ready", src_ready_out, 1);

    add(15, 16384, 1, 0);
    add(15, -16384, 0, 0);
    add(15, 49152, 2, 0);
    add(15, 64'sd2147483648, 32767, 1);
    add(15, -64'sd2147483648, -32768, 1);
    add(63, -1, 0, 0);
    add(63, -64'sd68719476736, -1, 0);
    add(0, 12345, 12345, 0);
    add(0, 32767, 32767, 0);
    add(0, 32768, 32767, 1);
    add(0, -32768, -32768, 0);
    add(0, -32769, -32768, 1);
    add(1, 3, 2, 0);
    add(1, -3, -1, 0);
    add(36, 64'sd34359738368, 1, 0);
    add(40, 64'sd34359738367, 0, 0);
    add(16, -98304, -1, 0);

    foreach (vq[i]) apply(vq[i]);

    chk("sat_flag_after_table", sat_flag, 1);
    chk("sat_count_after_table", sat_count, 4);
    clear_sat = 1'b1;
    tick();
    clear_sat = 1'b0;
    exp_cnt = 0;
    chk("clear_flag", sat_flag, 0);
    chk("clear_count", sat_count, 0);

    // clear coinciding with a saturated write: set wins
    shift = 6'd15; src_data_in = 37'sd2147483648; src_valid_in = 1'b1; dst_ready_in = 1'b1;
    tick();
    src_valid_in = 1'b0;
    clear_sat = 1'b1;
    tick();
    clear_sat = 1'b0;
    chk("clear_vs_set_flag", sat_flag, 1);
    chk("clear_vs_set_count", sat_count, 1);
    chk("clear_vs_set_data", $signed(dst_data_out), 32767);
    tick();

    // fill against backpressure, then drain in order
    dst_ready_in = 1'b0; shift = 6'd0; nin = 1; acc = 0;
    for (int c = 0; c < 12; c++) begin
      src_valid_in = 1'b1;
      src_data_in  = 37'(nin);
      if (src_ready_out) begin nin++; acc++; end
      tick();
    end
    chk("bp_accepted", acc, 8);
    chk("bp_ready_low", src_ready_out, 0);
    chk("bp_level_full", level, 8);
    dst_ready_in = 1'b1; nout = 1;
    for (int c = 0; c < 40 && nout <= 10; c++) begin
      src_valid_in = (nin <= 10);
      src_data_in  = 37'(nin);
      acc_now = src_valid_in && src_ready_out;
      if (dst_valid_out) begin
        chk("bp_data", $signed(dst_data_out), nout);
        nout++;
      end
      tick();
      if (acc_now) nin++;
    end
    src_valid_in = 1'b0;
    chk("bp_all_out", nout, 11);
    tick(); tick();
    chk("bp_empty", level, 0);

    // streaming on both sides with occupancy held at 4
    nin = 1; nout = 1; lvl_checks = 0;
    for (int c = 0; c < 80 && nout <= 30; c++) begin
      src_valid_in = (nin <= 30);
      src_data_in  = 37'(nin);
      dst_ready_in = (nin > 5);
      if (dst_ready_in && lvl_checks < 20) begin
        chk("stream_level", level, 4);
        lvl_checks++;
      end
      acc_now = src_valid_in && src_ready_out;
      if (dst_valid_out && dst_ready_in) begin
        chk("stream_data", $signed(dst_data_out), nout);
        nout++;
      end
      tick();
      if (acc_now) nin++;
    end
    src_valid_in = 1'b0;
    chk("stream_all_out", nout, 31);
    chk("stream_level_checks", lvl_checks, 20);

    // reset mid-stream at level 5 with S1 occupied
    dst_ready_in = 1'b0; nin = 200; acc = 0;
    for (int c = 0; c < 20 && acc < 6; c++) begin
      src_valid_in = 1'b1;
      src_data_in  = 37'(nin);
      if (src_ready_out) begin nin++; acc++; end
      tick();
    end
    src_valid_in = 1'b0;
    chk("pre_rst_level", level, 5);
    chk("pre_rst_sat_count", sat_count, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_dst_valid", dst_valid_out, 0);
    chk("mid_rst_sat_count", sat_count, 0);
    chk("mid_rst_sat_flag", sat_flag, 0);
    chk("mid_rst_src_ready", src_ready_out, 1);
    dst_ready_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("mid_rst_no_stale", dst_valid_out, 0);
    end
    v77.sh = 6'd0; v77.din = 37'sd77; v77.q = 16'd77; v77.sat = 1'b0;
    apply(v77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
